spio_counter_sampler: RTL and testbench
=======================================

Name: spio_counter_sampler

Overview:
- Controller and arbiter for the shared packet/error counter read port (6-bit address out, 32-bit combinational data back).
- Two requesters share the port: a host register-read port and an internal periodic sweeper.
- Every PERIOD cycles the sweeper reads all 64 counter addresses and streams (addr, data) records out over a valid/ready interface for the link-statistics logger.
- Host reads are interleaved with the sweep under round-robin arbitration.

Parameters:
- CTRA_BITS, 6, counter address width; sweep covers 0 .. 2^CTRA_BITS-1.
- CTRD_BITS, 32, counter data width.
- PERIOD, 4096, sweep start interval in CLK_IN cycles; must be ≥ 2^CTRA_BITS*3.
- PTMR_BITS, 16, period timer width; must satisfy 2^PTMR_BITS ≥ PERIOD.

Ports:
- CLK_IN  in  1  clock.
- RESET_IN  in  1  reset: asynchronous, active-high.
- ctr_addr  out  CTRA_BITS  address to counter block (registered).
- ctr_data  in  CTRD_BITS  counter value (combinational from ctr_addr).
- host_req  in  1  host read request; sampled only while host_ack=0.
- host_addr  in  CTRA_BITS  host read address; held stable while host_req=1.
- host_ack  out  1  one-cycle pulse: host_data valid.
- host_data  out  CTRD_BITS  host read result; held until the next ack.
- smp_vld  out  1  sample record valid.
- smp_rdy  in  1  downstream ready.
- smp_addr  out  CTRA_BITS  counter address of the record.
- smp_data  out  CTRD_BITS  counter value, or delta if the feature is enabled.
- smp_last  out  1  high on the record for address 2^CTRA_BITS-1.
- sweep_busy  out  1  sweep pending or in progress.
- sweep_ovr  out  1  sticky overrun flag.
- ovr_clr  in  1  clears sweep_ovr.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; sweep index 0; period timer 0; rr_last=SWEEP.
- Period timer: free-running, counts 0..PERIOD-1 and wraps. A tick occurs in the wrap cycle; the first tick is PERIOD cycles after reset release.
- Tick handling:
  - Tick with sweep_busy=0: set sweep_pend.
  - Tick with sweep_busy=1: set sweep_ovr; the tick is otherwise discarded. The in-progress sweep is not restarted.
- ovr_clr coincident with an overrun tick: set wins.
- sweep_busy = sweep_pend OR (FSM in SWP_RD/SWP_OUT).
- FSM states: IDLE, HOST_RD, SWP_RD, SWP_OUT.
- IDLE arbitration between h = host_req & ~host_ack and s = sweep_pend:
  - Only h: go to HOST_RD.
  - Only s: go to SWP_RD.
  - Both: grant the requester opposite to rr_last.
  - On a grant, update rr_last.
- HOST_RD (1 cycle):
  - ctr_addr <= host_addr on entry.
  - Next edge: host_data <= ctr_data, host_ack <= 1, go to IDLE.
  - Latency: req sampled at edge E0, ack high in cycle after E1.
- SWP_RD (1 cycle):
  - ctr_addr <= idx on entry.
  - Next edge: smp_addr <= idx, smp_data <= ctr_data (or delta), smp_last <= (idx == all ones), smp_vld <= 1, go to SWP_OUT.
- SWP_OUT:
  - Hold all smp_* stable until smp_vld & smp_rdy.
  - On handshake: smp_vld <= 0, idx <= idx+1 (wraps), go to IDLE.
  - If smp_last, clear sweep_pend, and sweep_busy falls.
  - No host read is granted while in SWP_OUT; a stalled smp_rdy blocks the host.
- Minimum sweep cost: 3 cycles per entry with smp_rdy tied high and no host traffic (IDLE, SWP_RD, SWP_OUT).
- Reset mid-operation: everything returns to reset values immediately (asynchronous). A partial sweep is abandoned, and the next sweep starts at address 0.
- sweep_pend is set in the tick cycle and is first visible to arbitration the following cycle.

Optional Feature:
- Macro: SPIO_SAMPLER_DELTA_EN.
- Defined:
  - Instantiate a 2^CTRA_BITS x CTRD_BITS snapshot array, reset to 0.
  - In SWP_RD: smp_data <= ctr_data - snap[idx] (modulo 2^CTRD_BITS, so counter wrap yields the correct delta), and snap[idx] <= ctr_data.
  - Host reads always return raw values and never update snap.
  - The first sweep after reset reports raw values.
- Undefined: no array; smp_data carries the raw value.

Decomposition:
- Shared package/header holds: CTRA_BITS/CTRD_BITS defaults, address-field constants (bits [5:4]: packet, tp0, tp1, tp2 counters), FSM state encoding, and the rr_last encoding.
- One sub-module: spio_sampler_period_timer (counter plus tick output). The FSM, arbiter and optional snapshot array stay in the top.

Test Plan:
- PERIOD=256, smp_rdy=1, counter model returning data = 0x1000+addr:
  - 64 records, addresses 0..63 in order, data 0x1000..0x103F, smp_last only on 63.
  - First smp_vld 3 cycles after the first tick; sweep_busy drops after record 63.
- Host read of addr 0x15 while idle: host_ack pulses in the cycle after E1 with host_data=0x1015; exactly one pulse while req is held.
- Host req held continuously during a sweep: grants alternate host, sweep, host, …; the sweep completes all 64 records; each ack carries correct data.
- smp_rdy held low for 20 cycles mid-sweep at idx 10:
  - smp_addr/smp_data stable throughout; the host is not acked until the handshake.
  - Resumes at idx 11.
- smp_rdy=0 across the next tick: sweep_ovr=1 and no restart. Pulsing ovr_clr clears it; ovr_clr coincident with a tick leaves it set.
- Delta feature: counter 0x3 goes 0xFFFFFFF0 then 0x00000010 on consecutive sweeps → second record data 0x20.
- Reset asserted mid-sweep at idx 30 → all outputs 0 at once; the next sweep starts at 0 after the first tick, PERIOD cycles later.

Source files
------------

// File: rtl/spio_counter_sampler_pkg.sv
`default_nettype none
// ============================================================================
// spio_counter_sampler_pkg : shared widths, counter address map, FSM/RR codes
// Revision: 1.0
// ============================================================================
package spio_counter_sampler_pkg;

  localparam int c_CTRA_BITS_DEF = 6;
  localparam int c_CTRD_BITS_DEF = 32;

  // Counter address map: bits [5:4] select the counter group.
  localparam int         c_FLD_MSB    = 5;
  localparam int         c_FLD_LSB    = 4;
  localparam logic [1:0] c_FLD_PACKET = 2'd0;
  localparam logic [1:0] c_FLD_TP0    = 2'd1;
  localparam logic [1:0] c_FLD_TP1    = 2'd2;
  localparam logic [1:0] c_FLD_TP2    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOST_RD = 2'd1,
    ST_SWP_RD  = 2'd2,
    ST_SWP_OUT = 2'd3
  } state_e;

  typedef enum logic {
    RR_HOST  = 1'b0,
    RR_SWEEP = 1'b1
  } rr_e;

endpackage
`default_nettype wire

// File: rtl/spio_sampler_period_timer.sv
`default_nettype none
// ============================================================================
// spio_sampler_period_timer : free-running 0..PERIOD-1 counter, tick on wrap
// Revision: 1.0
// ============================================================================
module spio_sampler_period_timer #(
  parameter int PERIOD    = 4096,
  parameter int PTMR_BITS = 16
) (
  input  logic CLK_IN,
  input  logic RESET_IN,
  output logic tick_o
);

  localparam logic [PTMR_BITS-1:0] c_LAST = PTMR_BITS'(PERIOD - 1);

  logic [PTMR_BITS-1:0] cnt_q;
  logic [PTMR_BITS-1:0] cnt_d;

  assign tick_o = (cnt_q == c_LAST);
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spio_counter_sampler.sv
`default_nettype none
// ============================================================================
// spio_counter_sampler : arbitrates host reads and a periodic counter sweep
// on the shared counter port. Option macro: SPIO_SAMPLER_DELTA_EN. Rev 1.0
// ============================================================================
module spio_counter_sampler
  import spio_counter_sampler_pkg::*;
#(
  parameter int CTRA_BITS = c_CTRA_BITS_DEF,
  parameter int CTRD_BITS = c_CTRD_BITS_DEF,
  parameter int PERIOD    = 4096,
  parameter int PTMR_BITS = 16
) (
  input  logic                 CLK_IN,
  input  logic                 RESET_IN,
  output logic [CTRA_BITS-1:0] ctr_addr,
  input  logic [CTRD_BITS-1:0] ctr_data,
  input  logic                 host_req,
  input  logic [CTRA_BITS-1:0] host_addr,
  output logic                 host_ack,
  output logic [CTRD_BITS-1:0] host_data,
  output logic                 smp_vld,
  input  logic                 smp_rdy,
  output logic [CTRA_BITS-1:0] smp_addr,
  output logic [CTRD_BITS-1:0] smp_data,
  output logic                 smp_last,
  output logic                 sweep_busy,
  output logic                 sweep_ovr,
  input  logic                 ovr_clr
);

  state_e               state_q, state_d;
  rr_e                  rr_q, rr_d;
  logic [CTRA_BITS-1:0] idx_q, idx_d;
  logic                 pend_q, pend_d;
  logic                 ovr_q, ovr_d;
  logic [CTRA_BITS-1:0] ctr_addr_q, ctr_addr_d;
  logic                 host_ack_q, host_ack_d;
  logic [CTRD_BITS-1:0] host_data_q, host_data_d;
  logic                 smp_vld_q, smp_vld_d;
  logic [CTRA_BITS-1:0] smp_addr_q, smp_addr_d;
  logic [CTRD_BITS-1:0] smp_data_q, smp_data_d;
  logic                 smp_last_q, smp_last_d;

  logic                 w_tick;
  logic                 w_busy;
  logic                 w_host;
  logic                 w_swp;
  logic [CTRD_BITS-1:0] w_smp_val;

  spio_sampler_period_timer #(
    .PERIOD    (PERIOD),
    .PTMR_BITS (PTMR_BITS)
  ) u_timer (
    .CLK_IN   (CLK_IN),
    .RESET_IN (RESET_IN),
    .tick_o   (w_tick)
  );

`ifdef SPIO_SAMPLER_DELTA_EN
  localparam int c_DEPTH = 2 ** CTRA_BITS;

  logic [CTRD_BITS-1:0] snap_q [c_DEPTH];

  // Unsigned wrap of the subtraction keeps the delta correct across counter rollover.
  assign w_smp_val = ctr_data - snap_q[idx_q];

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        snap_q[i] <= '0;
      end
    end else if (state_q == ST_SWP_RD) begin
      snap_q[idx_q] <= ctr_data;
    end
  end
`else
  assign w_smp_val = ctr_data;
`endif

  assign w_busy = pend_q | (state_q == ST_SWP_RD) | (state_q == ST_SWP_OUT);
  assign w_host = host_req & ~host_ack_q;
  assign w_swp  = pend_q;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    ovr_d       = ovr_q;
    ctr_addr_d  = ctr_addr_q;
    host_ack_d  = 1'b0;
    host_data_d = host_data_q;
    smp_vld_d   = smp_vld_q;
    smp_addr_d  = smp_addr_q;
    smp_data_d  = smp_data_q;
    smp_last_d  = smp_last_q;

    // A tick during a sweep is dropped and only flagged; set beats clear.
    if (w_tick && w_busy) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
    if (w_tick && !w_busy) begin
      pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_host && (!w_swp || rr_q == RR_SWEEP)) begin
          state_d    = ST_HOST_RD;
          ctr_addr_d = host_addr;
          rr_d       = RR_HOST;
        end else if (w_swp) begin
          state_d    = ST_SWP_RD;
          ctr_addr_d = idx_q;
          rr_d       = RR_SWEEP;
        end
      end
      ST_HOST_RD: begin
        host_data_d = ctr_data;
        host_ack_d  = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_SWP_RD: begin
        smp_addr_d = idx_q;
        smp_data_d = w_smp_val;
        smp_last_d = &idx_q;
        smp_vld_d  = 1'b1;
        state_d    = ST_SWP_OUT;
      end
      ST_SWP_OUT: begin
        if (smp_rdy) begin
          smp_vld_d = 1'b0;
          idx_d     = idx_q + 1'b1;
          state_d   = ST_IDLE;
          if (smp_last_q) begin
            pend_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q     <= ST_IDLE;
      rr_q        <= RR_SWEEP;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      ovr_q       <= 1'b0;
      ctr_addr_q  <= '0;
      host_ack_q  <= 1'b0;
      host_data_q <= '0;
      smp_vld_q   <= 1'b0;
      smp_addr_q  <= '0;
      smp_data_q  <= '0;
      smp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
      ctr_addr_q  <= ctr_addr_d;
      host_ack_q  <= host_ack_d;
      host_data_q <= host_data_d;
      smp_vld_q   <= smp_vld_d;
      smp_addr_q  <= smp_addr_d;
      smp_data_q  <= smp_data_d;
      smp_last_q  <= smp_last_d;
    end
  end

  assign ctr_addr   = ctr_addr_q;
  assign host_ack   = host_ack_q;
  assign host_data  = host_data_q;
  assign smp_vld    = smp_vld_q;
  assign smp_addr   = smp_addr_q;
  assign smp_data   = smp_data_q;
  assign smp_last   = smp_last_q;
  assign sweep_busy = w_busy;
  assign sweep_ovr  = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_spio_counter_sampler.sv
`default_nettype none
// ============================================================================
// tb_spio_counter_sampler : directed tables, stall/overrun/reset sequences and
// randomized traffic against a counter-port reference model. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_spio_counter_sampler;

  localparam int P  = 256;
  localparam int NA = 64;
`ifdef SPIO_SAMPLER_DELTA_EN
  localparam bit DELTA = 1'b1;
`else
  localparam bit DELTA = 1'b0;
`endif

  logic        CLK_IN    = 1'b0;
  logic        RESET_IN  = 1'b1;
  logic [5:0]  ctr_addr;
  logic [31:0] ctr_data;
  logic        host_req  = 1'b0;
  logic [5:0]  host_addr = '0;
  logic        host_ack;
  logic [31:0] host_data;
  logic        smp_vld;
  logic        smp_rdy   = 1'b1;
  logic [5:0]  smp_addr;
  logic [31:0] smp_data;
  logic        smp_last;
  logic        sweep_busy;
  logic        sweep_ovr;
  logic        ovr_clr   = 1'b0;

  logic [31:0] mem      [NA];
  logic [31:0] last_raw [NA];
  logic [31:0] rec_data [NA];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc;
  int          exp_idx = 0;
  int          n_rec = 0;
  int          acks_between = 0;
  bit          chk_alt = 1'b0;
  logic [5:0]  req_addr = '0;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } hvec_t;
  hvec_t htab [6];

  spio_counter_sampler #(
    .CTRA_BITS (6),
    .CTRD_BITS (32),
    .PERIOD    (P),
    .PTMR_BITS (16)
  ) dut (
    .CLK_IN     (CLK_IN),
    .RESET_IN   (RESET_IN),
    .ctr_addr   (ctr_addr),
    .ctr_data   (ctr_data),
    .host_req   (host_req),
    .host_addr  (host_addr),
    .host_ack   (host_ack),
    .host_data  (host_data),
    .smp_vld    (smp_vld),
    .smp_rdy    (smp_rdy),
    .smp_addr   (smp_addr),
    .smp_data   (smp_data),
    .smp_last   (smp_last),
    .sweep_busy (sweep_busy),
    .sweep_ovr  (sweep_ovr),
    .ovr_clr    (ovr_clr)
  );

  assign ctr_data = mem[ctr_addr];

  initial forever #5 CLK_IN = ~CLK_IN;

  // Clock edges seen since reset release; the timer tick falls in cycle cyc%P == P-1.
  always @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: records come in strict address order, each carrying the
  // counter value (or its change since the previous sweep report).
  initial begin
    logic [31:0] expd;
    forever begin
      @(negedge CLK_IN);
      if (RESET_IN) begin
        exp_idx      = 0;
        acks_between = 0;
        for (int i = 0; i < NA; i++) last_raw[i] = '0;
      end else begin
        if (smp_vld && smp_rdy) begin
          expd = DELTA ? (mem[exp_idx] - last_raw[exp_idx]) : mem[exp_idx];
          last_raw[exp_idx] = mem[exp_idx];
          check("rec_addr", {26'd0, smp_addr}, exp_idx);
          check("rec_data", smp_data, expd);
          check("rec_last", {31'd0, smp_last}, (exp_idx == NA - 1) ? 32'd1 : 32'd0);
          if (chk_alt && exp_idx != 0) check("rr_alternate", acks_between, 1);
          acks_between      = 0;
          rec_data[exp_idx] = smp_data;
          exp_idx           = (exp_idx + 1) % NA;
          n_rec++;
        end
        if (host_ack) begin
          check("host_data", host_data, mem[req_addr]);
          acks_between++;
        end else if (host_req) begin
          req_addr = host_addr;
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctr_addr"},   {26'd0, ctr_addr}, 0);
    check({tag, "_host_ack"},   {31'd0, host_ack}, 0);
    check({tag, "_host_data"},  host_data, 0);
    check({tag, "_smp_vld"},    {31'd0, smp_vld}, 0);
    check({tag, "_smp_addr"},   {26'd0, smp_addr}, 0);
    check({tag, "_smp_data"},   smp_data, 0);
    check({tag, "_smp_last"},   {31'd0, smp_last}, 0);
    check({tag, "_sweep_busy"}, {31'd0, sweep_busy}, 0);
    check({tag, "_sweep_ovr"},  {31'd0, sweep_ovr}, 0);
  endtask

  task automatic wait_vld(input string nm);
    int n = 0;
    while (!smp_vld && n < 600) begin step(); n++; end
    if (!smp_vld) check(nm, {31'd0, smp_vld}, 1);
  endtask

  task automatic wait_nrec(input int target, input string nm);
    int n = 0;
    while (n_rec < target && n < 3000) begin step(); n++; end
    if (n_rec < target) check(nm, n_rec, target);
  endtask

  task automatic accept_one();
    wait_vld("accept_timeout");
    smp_rdy = 1'b1;
    step();
    smp_rdy = 1'b0;
  endtask

  task automatic host_read(input logic [5:0] a, input logic [31:0] d);
    int lat = 0;
    host_addr = a;
    host_req  = 1'b1;
    while (!host_ack && lat < 20) begin step(); lat++; end
    check("host_latency", lat, 2);
    check("host_tab_data", host_data, d);
    host_req = 1'b0;
    step();
    check("host_single_pulse", {31'd0, host_ack}, 0);
  endtask

  task automatic pulse_clr();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
  endtask

  initial begin
    logic [5:0]  cap_a;
    logic [31:0] cap_d;
    int          n;

    htab[0] = '{6'h15, 32'h0000_1015};
    htab[1] = '{6'h00, 32'h0000_1000};
    htab[2] = '{6'h3F, 32'h0000_103F};
    htab[3] = '{6'h03, 32'h0000_1003};
    htab[4] = '{6'h2A, 32'h0000_102A};
    htab[5] = '{6'h10, 32'h0000_1010};
    for (int i = 0; i < NA; i++) begin
      mem[i]      = 32'h1000 + i;
      last_raw[i] = '0;
      rec_data[i] = '0;
    end

    repeat (3) step();
    check_zero("reset");
    RESET_IN = 1'b0;

    for (int k = 0; k < 6; k++) host_read(htab[k].addr, htab[k].data);

    // First sweep: raw data, first record PERIOD+2 edges after release.
    mem[3] = 32'hFFFF_FFF0;
    wait_vld("first_vld_timeout");
    check("first_vld_cycle", cyc, P + 2);
    check("first_addr", {26'd0, smp_addr}, 0);
    wait_nrec(64, "sweep1_timeout");
    check("busy_after_last", {31'd0, sweep_busy}, 0);
    check("sweep1_rec0", rec_data[0], 32'h1000);
    check("sweep1_rec63", rec_data[63], 32'h103F);
    mem[3] = 32'h0000_0010;

    // Second sweep with the host requesting continuously.
    chk_alt   = 1'b1;
    host_addr = 6'($urandom);
    host_req  = 1'b1;
    n = 0;
    while (n_rec < 128 && n < 1500) begin
      step();
      if (host_ack) host_addr = 6'($urandom);
      n++;
    end
    if (n_rec < 128) check("sweep2_timeout", n_rec, 128);
    chk_alt  = 1'b0;
    host_req = 1'b0;
    smp_rdy  = 1'b0;
    check("delta_wrap_rec3", rec_data[3], DELTA ? 32'h20 : 32'h10);

    // Third sweep: stall on idx 10 with the host waiting.
    for (int k = 0; k < 10; k++) accept_one();
    wait_vld("stall_vld_timeout");
    check("stall_addr", {26'd0, smp_addr}, 10);
    cap_a     = smp_addr;
    cap_d     = smp_data;
    host_addr = 6'h22;
    host_req  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("stall_vld", {31'd0, smp_vld}, 1);
      check("stall_addr_hold", {26'd0, smp_addr}, {26'd0, cap_a});
      check("stall_data_hold", smp_data, cap_d);
      check("stall_host_blocked", {31'd0, host_ack}, 0);
    end
    smp_rdy = 1'b1;
    step();
    n = 0;
    while (!host_ack && n < 10) begin step(); n++; end
    check("host_after_stall", {31'd0, host_ack}, 1);
    host_req = 1'b0;
    wait_vld("resume_timeout");
    check("resume_addr", {26'd0, smp_addr}, 11);
    wait_nrec(192, "sweep3_timeout");

    // Fourth sweep: stall across a tick -> overrun, no restart.
    pulse_clr();
    check("ovr_cleared_pre", {31'd0, sweep_ovr}, 0);
    smp_rdy = 1'b0;
    for (int k = 0; k < 5; k++) accept_one();
    wait_vld("ovr_vld_timeout");
    repeat (P + 10) step();
    check("ovr_set", {31'd0, sweep_ovr}, 1);
    check("ovr_busy", {31'd0, sweep_busy}, 1);
    check("ovr_no_restart", {26'd0, smp_addr}, 5);
    smp_rdy = 1'b1;
    step();
    wait_vld("ovr_resume_timeout");
    check("ovr_resume_addr", {26'd0, smp_addr}, 6);
    wait_nrec(256, "sweep4_timeout");
    pulse_clr();
    check("ovr_clr", {31'd0, sweep_ovr}, 0);

    // Fifth sweep: clear request landing on an overrun tick.
    smp_rdy = 1'b0;
    wait_vld("sweep5_vld_timeout");
    n = 0;
    while (cyc % P != P - 1 && n < P + 5) begin step(); n++; end
    pulse_clr();
    check("ovr_set_beats_clr", {31'd0, sweep_ovr}, 1);
    smp_rdy = 1'b1;
    wait_nrec(320, "sweep5_timeout");
    pulse_clr();
    check("ovr_clr2", {31'd0, sweep_ovr}, 0);

    // Randomized traffic.
    for (int c = 0; c < 1200; c++) begin
      smp_rdy = ($urandom_range(0, 3) != 0);
      if (host_ack) begin
        host_req = 1'b0;
      end else if (!host_req && $urandom_range(0, 5) == 0) begin
        host_addr = 6'($urandom);
        host_req  = 1'b1;
      end
      step();
    end
    host_req = 1'b0;
    smp_rdy  = 1'b1;

    // Asynchronous reset in the middle of a sweep.
    n = 0;
    while (!(smp_vld && smp_addr == 6'd30) && n < 1500) begin step(); n++; end
    check("reach_idx30", {26'd0, smp_addr}, 30);
    RESET_IN = 1'b1;
    #1;
    check_zero("mid_reset");
    step();
    step();
    RESET_IN = 1'b0;
    wait_vld("post_reset_timeout");
    check("post_reset_vld_cycle", cyc, P + 2);
    check("post_reset_addr", {26'd0, smp_addr}, 0);
    n = 0;
    while (exp_idx != 0 || n < 4) begin
      if (n > 400) break;
      step();
      n++;
    end
    check("post_reset_sweep_done", exp_idx, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
